snitch_fpga_dw_serdes: RTL and testbench
========================================

Name: snitch_fpga_dw_serdes

Overview:
- Parametrised bidirectional data-width converter on the eFPGA side. Links a narrow ASIC beat interface (AsicDW) to a wide memory port (MemDW).
- Request path: assembles Stages = MemDW/AsicDW write beats into one wide write with byte strobes. A read is a single beat.
- Response path: read data is buffered in a RspDepth-entry FIFO and serialised back MSB-first.
- A credit counter bounds outstanding reads, so the response FIFO never overflows.

Parameters:
- AsicAW, 8, ASIC address width; must be ≤ MemAW.
- AsicDW, 4, ASIC beat width; must be one of 4, 8, 16.
- MemAW, 10, memory address width.
- MemDW, 32, memory data width; must be a multiple of 8 and ≥ 2*AsicDW.
- RspDepth, 2, response FIFO depth, which is also the maximum number of outstanding reads (≥1).
- HalfHS, 1, if 1, response beats ignore asic_rsp_ready_i.
- Stages, MemDW/AsicDW, derived; do not override.
- StrbWidth, MemDW/8, derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- asic_req_addr_i  in  AsicAW  word address, sampled on the first beat
- asic_req_data_i  in  AsicDW  write beat data, MSB-first
- asic_req_write_i  in  1  1=write burst, 0=read
- asic_req_wstrb_i  in  1  per-beat enable
- asic_req_valid_i  in  1  beat valid
- asic_req_ready_o  out  1  beat accepted
- asic_rsp_data_o  out  AsicDW  read beat, MSB-first
- asic_rsp_valid_o  out  1  response beat valid
- asic_rsp_ready_i  in  1  response beat ready (unused when HalfHS=1)
- mem_req_addr_o  out  MemAW  zero-extended address
- mem_req_data_o  out  MemDW  assembled write data
- mem_req_write_o  out  1  write flag
- mem_req_wstrb_o  out  StrbWidth  byte strobes
- mem_req_valid_o  out  1  request valid
- mem_req_ready_i  in  1  request accepted
- mem_rsp_data_i  in  MemDW  read data (only reads produce responses)
- mem_rsp_valid_i  in  1  response valid
- mem_rsp_ready_o  out  1  FIFO not full
- asic_err_o  out  1  sticky protocol error (tied 0 unless DW_SERDES_ERR_EN)

Behaviour:
- Reset: all outputs 0 except mem_rsp_ready_o=1. Request FSM to IDLE, counters 0, FIFO empty.
- Request FSM states: IDLE, COMBINE, ISSUE.
- IDLE:
  - asic_req_ready_o = (credits < RspDepth) || asic_req_write_i.
  - Read beat accepted: latch address, go to ISSUE.
  - Write beat accepted: latch address; beat goes to bits [MemDW-1 -: AsicDW]; beat counter = 1; go to COMBINE.
- COMBINE: ready=1. Beat n is placed at bits [MemDW-1-n*AsicDW -: AsicDW]. When beat Stages-1 is accepted, go to ISSUE.
- Byte strobe: strobe[k] = AND of the beat strobes covering byte k. For AsicDW=16, each beat strobe drives both of its bytes.
- ISSUE:
  - asic_req_ready_o=0; mem_req_valid_o=1 from registers, starting the cycle after the last beat.
  - Address, data, write and wstrb stay stable until mem_req_ready_i.
  - On handshake, go to IDLE; credits +1 if read.
  - Read wstrb = '0; read data = '0.
- Credits: +1 on read issue, −1 when the last beat of a word is serialised. Both in the same cycle leaves credits unchanged. Credits never exceed RspDepth.
- FIFO:
  - Push on mem_rsp_valid_i && mem_rsp_ready_o.
  - The head stays in the FIFO until its last beat is sent.
  - Push and pop in the same cycle are allowed when the FIFO is full.
- Serialiser:
  - While the FIFO is non-empty: asic_rsp_valid_o=1 and data = head[MemDW-1-c*AsicDW -: AsicDW], where c is the beat counter.
  - c advances on (HalfHS ? 1 : asic_rsp_ready_i).
  - When c = Stages-1 advances: pop, c=0.
  - A back-to-back word follows with zero bubble.
  - First beat is valid the cycle after the push.
  - When HalfHS=0, data is held stable while stalled.
- Reset mid-burst: a partial write is discarded; no memory request is issued.

Optional Feature:
- DW_SERDES_ERR_EN defined, in COMBINE:
  - If a beat arrives with asic_req_write_i=0 or with an address different from the latched address, asic_err_o is set and stays set until reset.
  - The partial burst is dropped and the FSM goes to IDLE without issuing.
  - The offending beat is accepted and discarded.
- Undefined: write and address after beat 0 are ignored; asic_err_o=0.

Test Plan:
- Write, AsicDW=4/MemDW=32, addr 0x12, beats 1..8, all strobes 1 → after the 8th beat, one cycle later mem_req_valid with addr 0x012, data 0x12345678, wstrb 0xF, write=1.
- Same write but beats 0 and 1 strobe=0, mem_req_ready_i low 3 cycles → wstrb 0x7; valid held 4 cycles; asic_req_ready_o=0 until the handshake.
- Read addr 0x05, memory returns 0xDEADBEEF, HalfHS=1 → 8 consecutive beats D,E,A,D,B,E,E,F; credits back to 0.
- HalfHS=0, asic_rsp_ready_i toggling 1,0,1,… → each beat held through stalls; order preserved; no data loss.
- RspDepth=2, three reads with no memory response → third read not accepted (ready=0) until the first word fully serialised.
- rst_ni asserted after 4 write beats → no mem_req_valid; all outputs at reset values. With DW_SERDES_ERR_EN, an address change on beat 3 → asic_err_o=1 and no request issued.

Source files
------------

// File: rtl/snitch_fpga_dw_serdes.sv
// snitch_fpga_dw_serdes: eFPGA-side width converter between a narrow ASIC beat
// interface (AsicDW) and a wide memory port (MemDW).
//   * Requests: Stages write beats are packed MSB-first into one wide write with
//     byte strobes; a read is a single beat.
//   * Responses: read words wait in a RspDepth-entry FIFO and are sent back
//     MSB-first, one AsicDW beat at a time.
//   * A credit counter limits outstanding reads to RspDepth so the response
//     FIFO can never overflow.
// Optional build macro: DW_SERDES_ERR_EN enables the sticky protocol-error
// check on continuation beats of a write burst (asic_err_o). Without it the
// write flag and address of continuation beats are ignored and asic_err_o is 0.
module snitch_fpga_dw_serdes #(
    parameter int unsigned AsicAW    = 8,
    parameter int unsigned AsicDW    = 4,
    parameter int unsigned MemAW     = 10,
    parameter int unsigned MemDW     = 32,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned HalfHS    = 1,
    parameter int unsigned Stages    = MemDW / AsicDW,
    parameter int unsigned StrbWidth = MemDW / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // ASIC request side
    input  logic [AsicAW-1:0]    asic_req_addr_i,
    input  logic [AsicDW-1:0]    asic_req_data_i,
    input  logic                 asic_req_write_i,
    input  logic                 asic_req_wstrb_i,
    input  logic                 asic_req_valid_i,
    output logic                 asic_req_ready_o,
    // ASIC response side
    output logic [AsicDW-1:0]    asic_rsp_data_o,
    output logic                 asic_rsp_valid_o,
    input  logic                 asic_rsp_ready_i,
    // Memory request side
    output logic [MemAW-1:0]     mem_req_addr_o,
    output logic [MemDW-1:0]     mem_req_data_o,
    output logic                 mem_req_write_o,
    output logic [StrbWidth-1:0] mem_req_wstrb_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    // Memory response side
    input  logic [MemDW-1:0]     mem_rsp_data_i,
    input  logic                 mem_rsp_valid_i,
    output logic                 mem_rsp_ready_o,
    // Sticky protocol error
    output logic                 asic_err_o
);

    localparam int unsigned CntW = (Stages > 1) ? $clog2(Stages) : 1;
    localparam int unsigned CrdW = $clog2(RspDepth + 1);
    localparam int unsigned PtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    localparam logic [CntW-1:0] LastBeat = CntW'(Stages - 1);
    localparam logic [CrdW-1:0] MaxCrd   = CrdW'(RspDepth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(RspDepth - 1);

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Combine = 2'd1,
        Issue   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Request assembly registers
    logic [AsicAW-1:0] addr_q, addr_d;
    logic [MemDW-1:0]  data_q, data_d;
    logic [Stages-1:0] bstrb_q, bstrb_d;   // one strobe bit per received beat
    logic              write_q, write_d;
    logic [CntW-1:0]   wbeat_q, wbeat_d;

    // Outstanding-read credits
    logic [CrdW-1:0]   credits_q, credits_d;

    // Response FIFO and serialiser
    logic [MemDW-1:0]  fifo_q [RspDepth];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CrdW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   rbeat_q, rbeat_d;

    logic              req_hs, first_acc, comb_acc, mem_hs, rd_issue;
    logic              bad_beat;
    logic              fifo_empty, fifo_full, push, pop, advance;
    logic [MemDW-1:0]  head;
    logic [AsicDW-1:0] rsp_beat;
    logic [StrbWidth-1:0] wstrb;

    assign req_hs    = asic_req_valid_i && asic_req_ready_o;
    assign first_acc = req_hs && (state_q == Idle);
    assign comb_acc  = req_hs && (state_q == Combine);
    assign mem_hs    = mem_req_valid_o && mem_req_ready_i;
    assign rd_issue  = mem_hs && !write_q;

`ifdef DW_SERDES_ERR_EN
    logic err_q;

    // A continuation beat must stay a write to the address latched on beat 0.
    assign bad_beat = (state_q == Combine) && asic_req_valid_i &&
                      (!asic_req_write_i || (asic_req_addr_i != addr_q));

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (comb_acc && bad_beat) begin
            err_q <= 1'b1;
        end
    end

    assign asic_err_o = err_q;
`else
    assign bad_beat   = 1'b0;
    assign asic_err_o = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            Idle: begin
                if (first_acc) begin
                    state_d = asic_req_write_i ? Combine : Issue;
                end
            end
            Combine: begin
                if (comb_acc) begin
                    if (bad_beat) begin
                        state_d = Idle;
                    end else if (wbeat_q == LastBeat) begin
                        state_d = Issue;
                    end
                end
            end
            Issue: begin
                if (mem_hs) begin
                    state_d = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

    // FSM outputs; no beat is accepted while reset is held so every output is
    // at its reset value during reset
    always_comb begin
        asic_req_ready_o = 1'b0;
        mem_req_valid_o  = 1'b0;
        unique case (state_q)
            Idle:    asic_req_ready_o = rst_ni && ((credits_q < MaxCrd) || asic_req_write_i);
            Combine: asic_req_ready_o = 1'b1;
            Issue:   mem_req_valid_o  = 1'b1;
            default: ;
        endcase
    end

    // Burst assembly: latch address on beat 0, place beat n at MSB-first slot n
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        bstrb_d = bstrb_q;
        write_d = write_q;
        wbeat_d = wbeat_q;
        if (first_acc) begin
            addr_d  = asic_req_addr_i;
            write_d = asic_req_write_i;
            data_d  = '0;
            bstrb_d = '0;
            if (asic_req_write_i) begin
                data_d[MemDW-1 -: AsicDW] = asic_req_data_i;
                bstrb_d[0]                = asic_req_wstrb_i;
                wbeat_d                   = CntW'(1);
            end
        end else if (comb_acc && !bad_beat) begin
            for (int i = 0; i < Stages; i++) begin
                if (wbeat_q == CntW'(i)) begin
                    data_d[MemDW-1-i*AsicDW -: AsicDW] = asic_req_data_i;
                    bstrb_d[i]                         = asic_req_wstrb_i;
                end
            end
            wbeat_d = wbeat_q + CntW'(1);
        end
    end

    // Burst assembly registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            data_q  <= '0;
            bstrb_q <= '0;
            write_q <= 1'b0;
            wbeat_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            bstrb_q <= bstrb_d;
            write_q <= write_d;
            wbeat_q <= wbeat_d;
        end
    end

    // Byte strobe k is the AND of every beat strobe that covers a bit of byte k
    always_comb begin
        wstrb = '0;
        for (int k = 0; k < StrbWidth; k++) begin
            wstrb[k] = 1'b1;
            for (int b = 0; b < 8; b++) begin
                wstrb[k] = wstrb[k] & bstrb_q[(MemDW - 1 - (8 * k + b)) / AsicDW];
            end
        end
    end

    assign mem_req_addr_o  = (state_q == Issue) ? MemAW'(addr_q) : '0;
    assign mem_req_write_o = (state_q == Issue) && write_q;
    assign mem_req_data_o  = mem_req_write_o ? data_q : '0;
    assign mem_req_wstrb_o = mem_req_write_o ? wstrb : '0;

    // Credits: +1 per issued read, -1 per fully serialised word
    always_comb begin
        credits_d = credits_q;
        if (rd_issue && !pop) begin
            credits_d = credits_q + CrdW'(1);
        end else if (!rd_issue && pop) begin
            credits_d = credits_q - CrdW'(1);
        end
    end

    // Credit register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= '0;
        end else begin
            credits_q <= credits_d;
        end
    end

    // Response FIFO control; a full FIFO still accepts when its head leaves
    assign fifo_empty      = (cnt_q == '0);
    assign fifo_full       = (cnt_q == MaxCrd);
    assign advance         = !fifo_empty && ((HalfHS != 0) || asic_rsp_ready_i);
    assign pop             = advance && (rbeat_q == LastBeat);
    assign mem_rsp_ready_o = !fifo_full || pop;
    assign push            = mem_rsp_valid_i && mem_rsp_ready_o;

    // FIFO pointer, occupancy and serialiser beat counter next state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        rbeat_d = rbeat_q;
        if (push) begin
            wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d  = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
            rbeat_d = '0;
        end else if (advance) begin
            rbeat_d = rbeat_q + CntW'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CrdW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CrdW'(1);
        end
    end

    // FIFO control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rbeat_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            rbeat_q <= rbeat_d;
        end
    end

    // FIFO storage; contents are only observed while the entry is occupied
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= mem_rsp_data_i;
        end
    end

    // Pick the current MSB-first beat of the head word
    always_comb begin
        head     = fifo_q[rptr_q];
        rsp_beat = '0;
        for (int i = 0; i < Stages; i++) begin
            if (rbeat_q == CntW'(i)) begin
                rsp_beat = head[MemDW-1-i*AsicDW -: AsicDW];
            end
        end
    end

    assign asic_rsp_valid_o = !fifo_empty;
    assign asic_rsp_data_o  = fifo_empty ? '0 : rsp_beat;

endmodule

// File: tb/tb_snitch_fpga_dw_serdes.sv
// Directed bench for snitch_fpga_dw_serdes. Instance dut uses HalfHS=1 and
// carries all request-path stimulus; instance dut0 uses HalfHS=0 and only
// exercises the response path with a stalling ASIC receiver.
module tb_snitch_fpga_dw_serdes;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    // dut (HalfHS=1)
    logic [7:0]  asic_req_addr_i;
    logic [3:0]  asic_req_data_i;
    logic        asic_req_write_i;
    logic        asic_req_wstrb_i;
    logic        asic_req_valid_i;
    logic        asic_req_ready_o;
    logic [3:0]  asic_rsp_data_o;
    logic        asic_rsp_valid_o;
    logic        asic_rsp_ready_i;
    logic [9:0]  mem_req_addr_o;
    logic [31:0] mem_req_data_o;
    logic        mem_req_write_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_valid_i;
    logic        mem_rsp_ready_o;
    logic        asic_err_o;

    // dut0 (HalfHS=0)
    logic [7:0]  z_req_addr_i;
    logic [3:0]  z_req_data_i;
    logic        z_req_write_i;
    logic        z_req_wstrb_i;
    logic        z_req_valid_i;
    logic        z_req_ready_o;
    logic [3:0]  z_rsp_data_o;
    logic        z_rsp_valid_o;
    logic        z_rsp_ready_i;
    logic [9:0]  z_mreq_addr_o;
    logic [31:0] z_mreq_data_o;
    logic        z_mreq_write_o;
    logic [3:0]  z_mreq_wstrb_o;
    logic        z_mreq_valid_o;
    logic        z_mreq_ready_i;
    logic [31:0] z_mrsp_data_i;
    logic        z_mrsp_valid_i;
    logic        z_mrsp_ready_o;
    logic        z_err_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    snitch_fpga_dw_serdes #(.HalfHS(1)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .asic_req_addr_i (asic_req_addr_i),
        .asic_req_data_i (asic_req_data_i),
        .asic_req_write_i(asic_req_write_i),
        .asic_req_wstrb_i(asic_req_wstrb_i),
        .asic_req_valid_i(asic_req_valid_i),
        .asic_req_ready_o(asic_req_ready_o),
        .asic_rsp_data_o (asic_rsp_data_o),
        .asic_rsp_valid_o(asic_rsp_valid_o),
        .asic_rsp_ready_i(asic_rsp_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_req_write_o (mem_req_write_o),
        .mem_req_wstrb_o (mem_req_wstrb_o),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_ready_o (mem_rsp_ready_o),
        .asic_err_o      (asic_err_o)
    );

    snitch_fpga_dw_serdes #(.HalfHS(0)) dut0 (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .asic_req_addr_i (z_req_addr_i),
        .asic_req_data_i (z_req_data_i),
        .asic_req_write_i(z_req_write_i),
        .asic_req_wstrb_i(z_req_wstrb_i),
        .asic_req_valid_i(z_req_valid_i),
        .asic_req_ready_o(z_req_ready_o),
        .asic_rsp_data_o (z_rsp_data_o),
        .asic_rsp_valid_o(z_rsp_valid_o),
        .asic_rsp_ready_i(z_rsp_ready_i),
        .mem_req_addr_o  (z_mreq_addr_o),
        .mem_req_data_o  (z_mreq_data_o),
        .mem_req_write_o (z_mreq_write_o),
        .mem_req_wstrb_o (z_mreq_wstrb_o),
        .mem_req_valid_o (z_mreq_valid_o),
        .mem_req_ready_i (z_mreq_ready_i),
        .mem_rsp_data_i  (z_mrsp_data_i),
        .mem_rsp_valid_i (z_mrsp_valid_i),
        .mem_rsp_ready_o (z_mrsp_ready_o),
        .asic_err_o      (z_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, asic_req_ready_o, 1'b0);
        check({tag, "_rsp_valid"}, asic_rsp_valid_o, 1'b0);
        check({tag, "_rsp_data"},  asic_rsp_data_o, 4'h0);
        check({tag, "_mem_valid"}, mem_req_valid_o, 1'b0);
        check({tag, "_mem_addr"},  mem_req_addr_o, 10'h0);
        check({tag, "_mem_data"},  mem_req_data_o, 32'h0);
        check({tag, "_mem_wstrb"}, mem_req_wstrb_o, 4'h0);
        check({tag, "_mem_write"}, mem_req_write_o, 1'b0);
        check({tag, "_rsp_ready"}, mem_rsp_ready_o, 1'b1);
        check({tag, "_err"},       asic_err_o, 1'b0);
    endtask

    // Drive n write beats of word d (MSB-first); bs bit i is beat i's strobe.
    // Beat alt_i carries address alt_a instead of a.
    task automatic write_burst(input logic [7:0] a, input logic [31:0] d, input logic [7:0] bs,
                               input int n, input int alt_i, input logic [7:0] alt_a);
        for (int i = 0; i < n; i++) begin
            asic_req_valid_i = 1'b1;
            asic_req_write_i = 1'b1;
            asic_req_addr_i  = (i == alt_i) ? alt_a : a;
            asic_req_data_i  = d[31-4*i -: 4];
            asic_req_wstrb_i = bs[i];
            if (i == 0) begin
                #1;
                check("wr_first_ready", asic_req_ready_o, 1'b1);
            end
            @(negedge clk_i);
        end
        asic_req_valid_i = 1'b0;
    endtask

    // Single read beat followed by an immediate memory handshake
    task automatic read_req(input logic [7:0] a);
        asic_req_valid_i = 1'b1;
        asic_req_write_i = 1'b0;
        asic_req_addr_i  = a;
        #1;
        check("rd_ready", asic_req_ready_o, 1'b1);
        @(negedge clk_i);
        asic_req_valid_i = 1'b0;
        check("rd_mem_valid", mem_req_valid_o, 1'b1);
        check("rd_mem_addr", mem_req_addr_o, {2'b00, a});
        check("rd_mem_write", mem_req_write_o, 1'b0);
        check("rd_mem_wstrb", mem_req_wstrb_o, 4'h0);
        check("rd_mem_data", mem_req_data_o, 32'h0);
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        check("rd_mem_valid_drop", mem_req_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd_word;
        logic [31:0] zw [3];
        logic [3:0]  zexp [24];
        int          idx;

        rst_ni           = 1'b0;
        asic_req_addr_i  = '0;
        asic_req_data_i  = '0;
        asic_req_write_i = 1'b0;
        asic_req_wstrb_i = 1'b0;
        asic_req_valid_i = 1'b0;
        asic_rsp_ready_i = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_rsp_data_i   = '0;
        mem_rsp_valid_i  = 1'b0;
        z_req_addr_i     = '0;
        z_req_data_i     = '0;
        z_req_write_i    = 1'b0;
        z_req_wstrb_i    = 1'b0;
        z_req_valid_i    = 1'b0;
        z_rsp_ready_i    = 1'b0;
        z_mreq_ready_i   = 1'b0;
        z_mrsp_data_i    = '0;
        z_mrsp_valid_i   = 1'b0;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        check("reset_z_rsp_ready", z_mrsp_ready_o, 1'b1);
        rst_ni = 1'b1;

        // Full write: addr 0x12, beats 1..8, all strobes
        write_burst(8'h12, 32'h1234_5678, 8'hFF, 8, -1, 8'h00);
        check("w1_valid", mem_req_valid_o, 1'b1);
        check("w1_addr", mem_req_addr_o, 10'h012);
        check("w1_data", mem_req_data_o, 32'h1234_5678);
        check("w1_wstrb", mem_req_wstrb_o, 4'hF);
        check("w1_write", mem_req_write_o, 1'b1);
        check("w1_req_ready", asic_req_ready_o, 1'b0);
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        check("w1_valid_drop", mem_req_valid_o, 1'b0);

        // Partial strobes (beats 0,1 off) with memory back-pressure for 3 cycles
        write_burst(8'h34, 32'h9ABC_DEF0, 8'hFC, 8, -1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready_i = 1'b1;
            #1;
            check("w2_valid_hold", mem_req_valid_o, 1'b1);
            check("w2_req_ready", asic_req_ready_o, 1'b0);
            check("w2_data", mem_req_data_o, 32'h9ABC_DEF0);
            check("w2_wstrb", mem_req_wstrb_o, 4'h7);
            check("w2_addr", mem_req_addr_o, 10'h034);
            @(negedge clk_i);
        end
        mem_req_ready_i = 1'b0;
        check("w2_valid_drop", mem_req_valid_o, 1'b0);

        // Read 0x05 returning 0xDEADBEEF, HalfHS=1: eight consecutive beats
        read_req(8'h05);
        rd_word         = 32'hDEAD_BEEF;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = rd_word;
        #1;
        check("r1_mem_rsp_ready", mem_rsp_ready_o, 1'b1);
        check("r1_no_early_valid", asic_rsp_valid_o, 1'b0);
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check("r1_beat_valid", asic_rsp_valid_o, 1'b1);
            check("r1_beat_data", asic_rsp_data_o, rd_word[31-4*b -: 4]);
            @(negedge clk_i);
        end
        check("r1_done", asic_rsp_valid_o, 1'b0);

        // Credit limit: two reads in flight block a third until a word drains
        read_req(8'h01);
        read_req(8'h02);
        asic_req_valid_i = 1'b1;
        asic_req_write_i = 1'b0;
        asic_req_addr_i  = 8'h03;
        #1;
        check("crd_read_blocked", asic_req_ready_o, 1'b0);
        asic_req_write_i = 1'b1;
        #1;
        check("crd_write_allowed", asic_req_ready_o, 1'b1);
        asic_req_write_i = 1'b0;
        rd_word          = 32'hCAFE_F00D;
        mem_rsp_valid_i  = 1'b1;
        mem_rsp_data_i   = rd_word;
        @(negedge clk_i);
        mem_rsp_valid_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            check("crd_beat_data", asic_rsp_data_o, rd_word[31-4*b -: 4]);
            check("crd_still_blocked", asic_req_ready_o, 1'b0);
            @(negedge clk_i);
        end
        check("crd_released", asic_req_ready_o, 1'b1);
        @(negedge clk_i);
        asic_req_valid_i = 1'b0;
        check("crd_r3_valid", mem_req_valid_o, 1'b1);
        check("crd_r3_addr", mem_req_addr_o, 10'h003);
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;

        // HalfHS=0 instance: toggling ready, back-to-back words, push into a full FIFO while popping
        zw[0] = 32'h1357_9BDF;
        zw[1] = 32'h2468_ACE0;
        zw[2] = 32'hFEDC_BA98;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 8; b++) begin
                zexp[w*8+b] = zw[w][31-4*b -: 4];
            end
        end
        z_mrsp_valid_i = 1'b1;
        z_mrsp_data_i  = zw[0];
        @(negedge clk_i);
        z_mrsp_data_i  = zw[1];
        @(negedge clk_i);
        z_mrsp_valid_i = 1'b0;
        #1;
        check("z_full_not_ready", z_mrsp_ready_o, 1'b0);
        check("z_stall_valid", z_rsp_valid_o, 1'b1);
        check("z_stall_data", z_rsp_data_o, zexp[0]);
        idx = 0;
        for (int k = 0; k < 60 && idx < 24; k++) begin
            z_mrsp_valid_i = 1'b0;
            z_rsp_ready_i  = (k % 2 == 0);
            if (idx == 7 && z_rsp_ready_i) begin
                z_mrsp_valid_i = 1'b1;
                z_mrsp_data_i  = zw[2];
            end
            #1;
            if (idx == 7 && z_rsp_ready_i) begin
                check("z_full_push_pop_ready", z_mrsp_ready_o, 1'b1);
            end
            check("z_beat_valid", z_rsp_valid_o, 1'b1);
            check("z_beat_data", z_rsp_data_o, zexp[idx]);
            if (z_rsp_ready_i) idx++;
            @(negedge clk_i);
        end
        z_mrsp_valid_i = 1'b0;
        z_rsp_ready_i  = 1'b0;
        #1;
        check("z_all_beats", idx, 24);
        check("z_drained", z_rsp_valid_o, 1'b0);

        // Reset in the middle of a write burst discards it
        @(negedge clk_i);
        write_burst(8'h33, 32'hAAAA_5555, 8'hFF, 4, -1, 8'h00);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("midrst_no_req", mem_req_valid_o, 1'b0);
        end
        check("midrst_idle_ready", asic_req_ready_o, 1'b1);

        // Address change on beat 3 of a write burst
`ifdef DW_SERDES_ERR_EN
        write_burst(8'h20, 32'h0F1E_2D3C, 8'hFF, 4, 3, 8'h21);
        check("err_set", asic_err_o, 1'b1);
        check("err_no_req", mem_req_valid_o, 1'b0);
        @(negedge clk_i);
        check("err_sticky", asic_err_o, 1'b1);
        check("err_no_req_later", mem_req_valid_o, 1'b0);
        check("err_idle_ready", asic_req_ready_o, 1'b1);
`else
        write_burst(8'h20, 32'h0F1E_2D3C, 8'hFF, 8, 3, 8'h21);
        check("noerr_valid", mem_req_valid_o, 1'b1);
        check("noerr_addr", mem_req_addr_o, 10'h020);
        check("noerr_data", mem_req_data_o, 32'h0F1E_2D3C);
        check("noerr_wstrb", mem_req_wstrb_o, 4'hF);
        check("noerr_err", asic_err_o, 1'b0);
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        mem_req_ready_i = 1'b0;
        check("noerr_valid_drop", mem_req_valid_o, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
